// File: rtl/countdown_timer_if.sv
// countdown_timer_if: control/preset inputs and time/status outputs of the
// countdown timer, bundled so the timer and a stopwatch can share display and
// control wiring.
//   start_stop  : level run enable (1 = count, 0 = pause)
//   load        : one-cycle pulse, capture preset_* into the counters
//   preset_sec/preset_min/preset_hour : preset time (sec/min clamp to 59)
//   sec/min/hour: current time, registered
//   running     : counting this cycle (RUN state and start_stop)
//   done        : one-cycle pulse on reaching 0:0:0 by counting
//   expired     : sticky expiry flag, cleared by load or reset
interface countdown_timer_if;
  logic       start_stop;
  logic       load;
  logic [5:0] preset_sec;
  logic [5:0] preset_min;
  logic [3:0] preset_hour;
  logic [5:0] sec;
  logic [5:0] min;
  logic [3:0] hour;
  logic       running;
  logic       done;
  logic       expired;

  modport master (
    output start_stop, load, preset_sec, preset_min, preset_hour,
    input  sec, min, hour, running, done, expired
  );

  modport slave (
    input  start_stop, load, preset_sec, preset_min, preset_hour,
    output sec, min, hour, running, done, expired
  );
endinterface

// File: rtl/countdown_timer.sv
// countdown_timer: H:M:S down-counter with an internal one-second prescaler.
// Loaded with a preset, it counts down one second per tick while start_stop is
// high and flags expiry at 0:0:0.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset
//   tif  : countdown_timer_if.slave (controls, presets, time and status)
// Parameters:
//   TICK_DIV : clock cycles per second tick (>=1; 1 = tick every enabled clock)
//   DIV_W    : prescaler width, 2**DIV_W >= TICK_DIV
module countdown_timer #(
  parameter int TICK_DIV = 1,
  parameter int DIV_W    = 26
) (
  input  logic              clk,
  input  logic              rst,
  countdown_timer_if.slave  tif
);

  localparam logic [DIV_W-1:0] TICK_LAST = DIV_W'(TICK_DIV - 1);
  localparam logic [DIV_W-1:0] PRESC_ONE = {{(DIV_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_EXP} state_e;

  state_e           state_q, state_d;
  logic [5:0]       sec_q, sec_d, min_q, min_d;
  logic [3:0]       hour_q, hour_d;
  logic [DIV_W-1:0] presc_q, presc_d;
  logic             done_q, done_d;
  logic             running, expired;

  logic [5:0] ld_sec, ld_min;
  logic       ld_zero, counting, tick, at_one;

  assign ld_sec   = (tif.preset_sec > 6'd59) ? 6'd59 : tif.preset_sec;
  assign ld_min   = (tif.preset_min > 6'd59) ? 6'd59 : tif.preset_min;
  assign ld_zero  = (ld_sec == 6'd0) && (ld_min == 6'd0) && (tif.preset_hour == 4'd0);
  assign counting = (state_q == S_RUN) && tif.start_stop;
  assign tick     = counting && (presc_q == TICK_LAST);
  // The tick taking 0:0:1 to 0:0:0 is the only way to reach expiry.
  assign at_one   = (sec_q == 6'd1) && (min_q == 6'd0) && (hour_q == 4'd0);

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; load overrides everything, including a coincident tick.
  always_comb begin
    state_d = state_q;
    if (tif.load)            state_d = ld_zero ? S_IDLE : S_RUN;
    else if (tick && at_one) state_d = S_EXP;
  end

  // Output logic
  always_comb begin
    running = (state_q == S_RUN) && tif.start_stop;
    expired = (state_q == S_EXP);
  end

  // Counter / prescaler next values
  always_comb begin
    sec_d   = sec_q;
    min_d   = min_q;
    hour_d  = hour_q;
    presc_d = presc_q;
    done_d  = 1'b0;
    if (tif.load) begin
      sec_d   = ld_sec;
      min_d   = ld_min;
      hour_d  = tif.preset_hour;
      presc_d = '0;
    end else if (counting) begin
      presc_d = tick ? '0 : presc_q + PRESC_ONE;
      if (tick) begin
        done_d = at_one;
        // Borrow chain; RUN never holds 0:0:0 so no wrap below zero.
        if (sec_q != 6'd0) begin
          sec_d = sec_q - 6'd1;
        end else if (min_q != 6'd0) begin
          sec_d = 6'd59;
          min_d = min_q - 6'd1;
        end else if (hour_q != 4'd0) begin
          sec_d  = 6'd59;
          min_d  = 6'd59;
          hour_d = hour_q - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sec_q   <= '0;
      min_q   <= '0;
      hour_q  <= '0;
      presc_q <= '0;
      done_q  <= 1'b0;
    end else begin
      sec_q   <= sec_d;
      min_q   <= min_d;
      hour_q  <= hour_d;
      presc_q <= presc_d;
      done_q  <= done_d;
    end
  end

  assign tif.sec     = sec_q;
  assign tif.min     = min_q;
  assign tif.hour    = hour_q;
  assign tif.done    = done_q;
  assign tif.running = running;
  assign tif.expired = expired;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: two instances (TICK_DIV=1 and TICK_DIV=4) share
// one stimulus stream. A reference model counting total seconds predicts the
// outputs; predictions are queued by the driver and checked by a monitor.
module tb_countdown_timer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  countdown_timer_if if1();
  countdown_timer_if if4();

  assign if4.start_stop  = if1.start_stop;
  assign if4.load        = if1.load;
  assign if4.preset_sec  = if1.preset_sec;
  assign if4.preset_min  = if1.preset_min;
  assign if4.preset_hour = if1.preset_hour;

  countdown_timer #(.TICK_DIV(1), .DIV_W(26)) u_dut1 (.clk(clk), .rst(rst), .tif(if1));
  countdown_timer #(.TICK_DIV(4), .DIV_W(26)) u_dut4 (.clk(clk), .rst(rst), .tif(if4));

  typedef struct {
    int t;     // remaining time in seconds
    int mode;  // 0 idle, 1 run, 2 expired
    int pc;    // partial-second cycle count
  } mdl_t;

  typedef struct {
    int sec, min, hour;
    bit done, expired, running;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
  } entry_t;

  mdl_t   m1, m4;
  entry_t sb[$];
  int     checks = 0;
  int     errors = 0;

  task automatic chk(input string nm, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic step(input int d, input bit r, input bit ss, input bit ld,
                      input int ps, input int pm, input int ph,
                      inout mdl_t m, output exp_t e);
    bit dn;
    dn = 1'b0;
    if (r) begin
      m.t = 0; m.mode = 0; m.pc = 0;
    end else if (ld) begin
      m.t  = ph * 3600 + (pm > 59 ? 59 : pm) * 60 + (ps > 59 ? 59 : ps);
      m.pc = 0;
      m.mode = (m.t != 0) ? 1 : 0;
    end else if (m.mode == 1 && ss) begin
      if (m.pc == d - 1) begin
        m.pc = 0;
        if (m.t > 0) m.t = m.t - 1;
        if (m.t == 0) begin
          dn = 1'b1;
          m.mode = 2;
        end
      end else begin
        m.pc = m.pc + 1;
      end
    end
    e.sec     = m.t % 60;
    e.min     = (m.t / 60) % 60;
    e.hour    = m.t / 3600;
    e.done    = dn;
    e.expired = (m.mode == 2);
    e.running = (m.mode == 1) && ss;
  endtask

  // Drive one cycle of inputs at the falling edge and queue the prediction
  // for the state after the following rising edge.
  task automatic cyc(input bit r, input bit ss, input bit ld,
                     input int ps, input int pm, input int ph);
    entry_t en;
    @(negedge clk);
    rst             = r;
    if1.start_stop  = ss;
    if1.load        = ld;
    if1.preset_sec  = 6'(ps);
    if1.preset_min  = 6'(pm);
    if1.preset_hour = 4'(ph);
    step(1, r, ss, ld, ps, pm, ph, m1, en.a);
    step(4, r, ss, ld, ps, pm, ph, m4, en.b);
    sb.push_back(en);
  endtask

  task automatic idle(input int n, input bit ss);
    for (int i = 0; i < n; i++) cyc(1'b0, ss, 1'b0, 0, 0, 0);
  endtask

  task automatic cmp(input string tag, input exp_t e,
                     input logic [5:0] s, input logic [5:0] mi, input logic [3:0] h,
                     input logic dn, input logic ex, input logic rn);
    chk({tag, ".sec"},     int'(s),  e.sec);
    chk({tag, ".min"},     int'(mi), e.min);
    chk({tag, ".hour"},    int'(h),  e.hour);
    chk({tag, ".done"},    int'(dn), int'(e.done));
    chk({tag, ".expired"}, int'(ex), int'(e.expired));
    chk({tag, ".running"}, int'(rn), int'(e.running));
  endtask

  // Monitor: outputs are valid every cycle; check just after each rising edge.
  initial begin
    entry_t en;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        en = sb.pop_front();
        cmp("t1", en.a, if1.sec, if1.min, if1.hour, if1.done, if1.expired, if1.running);
        cmp("t4", en.b, if4.sec, if4.min, if4.hour, if4.done, if4.expired, if4.running);
      end
    end
  end

  initial begin
    int r, ss, ld, ps, pm, ph;
    m1 = '{0, 0, 0};
    m4 = '{0, 0, 0};
    if1.start_stop = 1'b0; if1.load = 1'b0;
    if1.preset_sec = '0; if1.preset_min = '0; if1.preset_hour = '0;

    // Reset, then a short countdown to expiry that must hold afterwards.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 1, 3, 0, 0);
    idle(14, 1'b1);

    // Borrow chain.
    cyc(0, 1, 1, 0, 0, 1);
    idle(1, 1'b1);
    cyc(0, 1, 1, 0, 1, 0);
    idle(1, 1'b1);

    // Pause / resume mid-second.
    cyc(0, 1, 1, 5, 0, 0);
    idle(6, 1'b1);
    idle(10, 1'b0);
    idle(4, 1'b1);

    // Load wins over a coincident tick; out-of-range seconds clamp.
    cyc(0, 1, 1, 10, 2, 0);
    cyc(0, 1, 1, 63, 0, 0);
    idle(2, 1'b1);
    cyc(0, 0, 1, 20, 61, 0);   // load while paused stays paused
    idle(3, 1'b0);

    // Expire, zero load, re-arm.
    cyc(0, 1, 1, 1, 0, 0);
    idle(5, 1'b1);
    cyc(0, 1, 1, 0, 0, 0);
    idle(2, 1'b1);
    cyc(0, 1, 1, 2, 0, 0);
    idle(10, 1'b1);

    // Reset mid-run, then start without load.
    cyc(0, 1, 1, 15, 30, 2);
    idle(3, 1'b1);
    cyc(1, 1, 0, 0, 0, 0);
    idle(5, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(0, 199) == 0);
      ld = ($urandom_range(0, 19) == 0);
      ss = ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(0, 63);
      pm = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 63) : 0;
      ph = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 15) : 0;
      cyc(r[0], ss[0], ld[0], ps, pm, ph);
    end

    @(posedge clk);
    #2;
    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
Name: countdown_timer

Overview:
- Down-counting H:M:S timer; the reverse-direction companion to the stopwatch.
- Loaded with a preset time, counts down one second per tick while enabled, and flags expiry at 0:0:0.
- Output widths and the run-enable semantics match the stopwatch, so both can share display and control logic.
- An internal prescaler generates the second tick from the system clock.

Parameters:
- TICK_DIV, 1, clock cycles per one-second tick. Must be ≥1; 1 means every enabled clock is a second, for fast simulation.
- DIV_W, 26, width of the prescaler counter. Must satisfy 2^DIV_W ≥ TICK_DIV.

Ports:
- clk  input  1  system clock, all logic on the rising edge
- rst  input  1  synchronous, active-high reset
- start_stop  input  1  level run enable: 1 = count, 0 = pause (holds time and prescaler)
- load  input  1  one-cycle pulse: capture the preset into the counters
- preset_sec  input  6  preset seconds, 0..59 (values >59 clamp to 59)
- preset_min  input  6  preset minutes, 0..59 (values >59 clamp to 59)
- preset_hour  input  4  preset hours, 0..15
- sec  output  6  current seconds, registered
- min  output  6  current minutes, registered
- hour  output  4  current hours, registered
- running  output  1  high while in RUN and start_stop=1
- done  output  1  one-cycle pulse on the transition into 0:0:0 by counting
- expired  output  1  sticky; high from the done cycle until the next load or rst

Behaviour:
- Reset (rst=1 at a clock edge, takes priority over everything):
  - sec/min/hour = 0; prescaler = 0; state = IDLE.
  - running = 0, done = 0, expired = 0.
  - Reset mid-count aborts immediately; no done pulse is produced.
- State machine:
  - IDLE: time is 0:0:0, nothing to count. load with a non-zero preset → RUN. load of 0:0:0 → stays IDLE, with no done and no expired.
  - RUN: counts down on each tick while start_stop=1.
    - A tick that takes the time from 0:0:1 to 0:0:0 → EXPIRED; done=1 for exactly that cycle; expired=1.
    - load with a non-zero preset reloads and stays in RUN.
    - load of zero → IDLE and clears the prescaler.
  - EXPIRED: time holds at 0:0:0 and start_stop is ignored. load non-zero → RUN with expired cleared. load zero → IDLE with expired cleared.
- Prescaler:
  - Increments only when state=RUN and start_stop=1.
  - A tick fires in the cycle where prescaler == TICK_DIV-1; the prescaler then wraps to 0.
  - When paused, the prescaler holds, so a resume continues the partial second.
  - Cleared by load and by rst.
- Decrement on a tick (registered; new value visible the cycle after the tick edge):
  - sec>0 → sec-1.
  - sec=0, min>0 → sec=59, min-1.
  - sec=0, min=0, hour>0 → sec=59, min=59, hour-1.
  - The time never wraps below 0:0:0.
- Load:
  - Counters take the clamped preset on the load edge.
  - load has priority over a simultaneous tick: the tick is discarded and the prescaler is cleared.
  - Load is accepted in any state, including while start_stop=0. Loading while paused leaves RUN paused.
- running is combinational from the registered state and start_stop (state==RUN && start_stop), with no extra latency.
- Simultaneous events:
  - load and start_stop rising in the same cycle: load applies, and counting begins on the following cycles.
  - Final tick while start_stop falls in the same cycle: a tick fires only if start_stop=1 in that cycle.
- All arithmetic is unsigned at the port widths; no internal value exceeds 59/59/15.

Test Plan:
- Reset/load: rst=1 for 2 cycles, then load 0:0:3 with TICK_DIV=1 and start_stop=1 → sec goes 3,2,1,0 on consecutive cycles. done is high only in the cycle sec becomes 0. expired stays 1 afterwards and time holds 0:0:0 for 10 more cycles.
- Borrow chain: load 1:0:0, run one tick → 0:59:59. Load 0:1:0, one tick → 0:0:59.
- Pause/resume with TICK_DIV=4: load 0:0:5, run 6 cycles → 0:0:4 with prescaler at 2. Drop start_stop for 10 cycles → no change, running=0. Raise start_stop → next decrement to 0:0:3 after exactly 2 cycles.
- Load priority: with TICK_DIV=1 and running, assert load with preset 0:2:10 in a tick cycle → next value is 0:2:10, not 0:2:9. A preset of sec=63 loads as 59.
- Zero load / re-arm: in EXPIRED, load 0:0:0 → IDLE with expired=0 and no done. Load 0:0:2 → counts to 0 and produces a single new done pulse.
- Mid-run reset: running at 2:30:15, assert rst for 1 cycle → all outputs 0, state IDLE, no done. start_stop=1 without a load → time stays 0:0:0.
